// File: rtl/phase_accum_nco.sv
// Phase accumulator NCO core: self-timed sample tick, wrapping phase register,
// registered sine-LUT address/negate. Optional quarter-wave folding via NCO_QUARTER_WAVE_EN.
module phase_accum_nco #(
  parameter int PHASE_W  = 16,
  parameter int STEP_W   = 8,
  parameter int STEP_SHL = 4,
  parameter int ADDR_W   = 8,
  parameter int DIV      = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [STEP_W-1:0]  i_step,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_load_phase,
  output logic [PHASE_W-1:0] o_phase,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_neg,
  output logic               o_valid,
  output logic               o_wrap
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_div_err
    $error("phase_accum_nco: DIV must be >= 2");
  end
`ifdef NCO_QUARTER_WAVE_EN
  if (ADDR_W > PHASE_W - 2) begin : g_addr_err
    $error("phase_accum_nco: ADDR_W must be <= PHASE_W-2 with quarter-wave folding");
  end
`else
  if (ADDR_W > PHASE_W) begin : g_addr_err
    $error("phase_accum_nco: ADDR_W must be <= PHASE_W");
  end
`endif

  logic [CNT_W-1:0]   cnt_r;
  logic [PHASE_W-1:0] phase_r;
  logic               wrap_pend_r;
  logic               upd_r;
  logic [ADDR_W-1:0]  addr_r;
  logic               neg_r;
  logic               valid_r;
  logic               wrap_r;

  logic               tick_s;
  logic [PHASE_W-1:0] step_ext_s;
  logic [PHASE_W-1:0] inc_s;
  logic [PHASE_W:0]   sum_s;
  logic               wrap_s;
  logic [ADDR_W-1:0]  addr_s;
  logic               neg_s;

  // Tick decode, step scaling and boundary-crossing detection.
  always_comb begin
    tick_s     = i_en && (cnt_r == CNT_LAST);
    step_ext_s = {{(PHASE_W - STEP_W){i_step[STEP_W-1]}}, i_step};
    inc_s      = step_ext_s << STEP_SHL;
    sum_s      = {1'b0, phase_r} + {1'b0, inc_s};
    // A negative increment crosses zero exactly when the add does not carry.
    if (inc_s == {PHASE_W{1'b0}}) begin
      wrap_s = 1'b0;
    end else if (inc_s[PHASE_W-1]) begin
      wrap_s = ~sum_s[PHASE_W];
    end else begin
      wrap_s = sum_s[PHASE_W];
    end
  end

`ifdef NCO_QUARTER_WAVE_EN
  logic [1:0]        q_s;
  logic [ADDR_W-1:0] idx_s;

  // Quarter-wave fold: odd quadrants mirror the index, upper half negates.
  always_comb begin
    q_s   = phase_r[PHASE_W-1 -: 2];
    idx_s = phase_r[PHASE_W-3 -: ADDR_W];
    case (q_s)
      2'd0: begin addr_s = idx_s;  neg_s = 1'b0; end
      2'd1: begin addr_s = ~idx_s; neg_s = 1'b0; end
      2'd2: begin addr_s = idx_s;  neg_s = 1'b1; end
      2'd3: begin addr_s = ~idx_s; neg_s = 1'b1; end
      default: begin addr_s = idx_s; neg_s = 1'b0; end
    endcase
  end
`else
  // Full-wave table: address is the top phase bits, no negation.
  always_comb begin
    addr_s = phase_r[PHASE_W-1 -: ADDR_W];
    neg_s  = 1'b0;
  end
`endif

  // Tick counter, phase register and pending wrap; load overrides tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      phase_r     <= {PHASE_W{1'b0}};
      wrap_pend_r <= 1'b0;
      upd_r       <= 1'b0;
    end else if (i_load) begin
      cnt_r       <= {CNT_W{1'b0}};
      phase_r     <= i_load_phase;
      wrap_pend_r <= 1'b0;
      upd_r       <= 1'b1;
    end else if (tick_s) begin
      cnt_r       <= {CNT_W{1'b0}};
      phase_r     <= sum_s[PHASE_W-1:0];
      wrap_pend_r <= wrap_s;
      upd_r       <= 1'b1;
    end else begin
      if (i_en) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      upd_r <= 1'b0;
    end
  end

  // Output stage: capture LUT address/negate/wrap one cycle after a phase update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_r  <= {ADDR_W{1'b0}};
      neg_r   <= 1'b0;
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      valid_r <= upd_r;
      if (upd_r) begin
        addr_r <= addr_s;
        neg_r  <= neg_s;
        wrap_r <= wrap_pend_r;
      end
    end
  end

  assign o_phase = phase_r;
  assign o_addr  = addr_r;
  assign o_neg   = neg_r;
  assign o_valid = valid_r;
  assign o_wrap  = wrap_r;

endmodule

// File: tb/tb_phase_accum_nco.sv
// Self-checking bench for phase_accum_nco (DIV=4): directed plan plus random
// stimulus against an arithmetic reference model.
module tb_phase_accum_nco;

  localparam int DIV = 4;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_en;
  logic [7:0]  i_step;
  logic        i_load;
  logic [15:0] i_load_phase;
  logic [15:0] o_phase;
  logic [7:0]  o_addr;
  logic        o_neg;
  logic        o_valid;
  logic        o_wrap;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_phase, m_cnt, m_pend, m_upd;
  int e_valid, e_addr, e_neg, e_wrap;
  int valid_seen;

  phase_accum_nco #(.DIV(DIV)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_step(i_step),
    .i_load(i_load), .i_load_phase(i_load_phase), .o_phase(o_phase),
    .o_addr(o_addr), .o_neg(o_neg), .o_valid(o_valid), .o_wrap(o_wrap)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int addr_of(input int ph);
`ifdef NCO_QUARTER_WAVE_EN
    int q, idx;
    q   = ph / 16384;
    idx = (ph / 64) % 256;
    return (q % 2 == 1) ? 255 - idx : idx;
`else
    return ph / 256;
`endif
  endfunction

  function automatic int neg_of(input int ph);
`ifdef NCO_QUARTER_WAVE_EN
    return (ph >= 32768) ? 1 : 0;
`else
    return (ph < 0) ? 1 : 0;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_pend = 0; m_upd = 0;
    e_valid = 0; e_addr = 0; e_neg = 0; e_wrap = 0;
  endtask

  task automatic compare_all();
    check_val("phase", o_phase, m_phase);
    check_val("valid", o_valid, e_valid);
    check_val("addr", o_addr, e_addr);
    check_val("neg", o_neg, e_neg);
    if (e_valid != 0) check_val("wrap", o_wrap, e_wrap);
    if (o_valid === 1'b1) valid_seen++;
  endtask

  // One clock cycle: apply inputs, advance model by the rules, compare.
  task automatic cyc(input int en, input int stp, input int ld, input int lph);
    int inc, sum, tick;
    i_en = en[0]; i_step = stp[7:0]; i_load = ld[0]; i_load_phase = lph[15:0];
    @(posedge i_clk);
    #1;
    if (m_upd != 0) begin
      e_valid = 1; e_addr = addr_of(m_phase); e_neg = neg_of(m_phase); e_wrap = m_pend;
    end else begin
      e_valid = 0;
    end
    tick = (en != 0 && m_cnt == DIV - 1) ? 1 : 0;
    if (ld != 0) begin
      m_phase = lph & 32'hFFFF; m_cnt = 0; m_pend = 0; m_upd = 1;
    end else if (tick != 0) begin
      inc = stp * 16;
      sum = m_phase + inc;
      m_pend = ((inc > 0 && sum > 65535) || (inc < 0 && sum < 0)) ? 1 : 0;
      m_phase = (sum + 65536) % 65536;
      m_cnt = 0; m_upd = 1;
    end else begin
      if (en != 0) m_cnt = m_cnt + 1;
      m_upd = 0;
    end
    compare_all();
  endtask

  initial begin
    int n;
    i_rst_n = 1'b0; i_en = 1'b0; i_step = 8'h00; i_load = 1'b0; i_load_phase = 16'h0000;
    model_reset();
    valid_seen = 0;
    repeat (3) @(negedge i_clk);
    check_val("rst_phase", o_phase, 32'h0);
    check_val("rst_addr", o_addr, 32'h0);
    check_val("rst_neg", o_neg, 32'h0);
    check_val("rst_valid", o_valid, 32'h0);
    check_val("rst_wrap", o_wrap, 32'h0);
    i_rst_n = 1'b1;

    // disabled: no strobes
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);
    check_val("idle_no_valid", valid_seen, 32'd0);

    // step +1: four ticks
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0);
    check_val("step1_phase", o_phase, 32'h0040);

    // load near top, then wrap
    cyc(1, 1, 1, 16'hFFF8);
    check_val("load_phase", o_phase, 32'hFFF8);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    check_val("wrap_up_phase", o_phase, 32'h0008);
    cyc(1, 1, 0, 0);
    check_val("wrap_up_flag", o_wrap, 32'h1);

    // load 0, step -4: borrow
    cyc(1, -4, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, -4, 0, 0);
    check_val("wrap_dn_phase", o_phase, 32'hFFC0);
    cyc(1, -4, 0, 0);
    check_val("wrap_dn_flag", o_wrap, 32'h1);
`ifdef NCO_QUARTER_WAVE_EN
    check_val("wrap_dn_addr", o_addr, 32'h00);
    check_val("wrap_dn_neg", o_neg, 32'h1);
    cyc(0, 0, 1, 16'h4000);
    cyc(0, 0, 0, 0);
    check_val("q1_addr", o_addr, 32'hFF);
    check_val("q1_neg", o_neg, 32'h0);
    cyc(0, 0, 1, 16'h8000);
    cyc(0, 0, 0, 0);
    check_val("q2_addr", o_addr, 32'h00);
    check_val("q2_neg", o_neg, 32'h1);
`else
    check_val("wrap_dn_addr", o_addr, 32'hFF);
    check_val("wrap_dn_neg", o_neg, 32'h0);
`endif

    // pause enable at count=2, resume, load on the tick cycle
    cyc(1, 3, 1, 0);
    cyc(1, 3, 0, 0);
    cyc(1, 3, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 3, 0, 0);
    check_val("pause_hold", o_phase, 32'h0);
    cyc(1, 3, 0, 0);
    check_val("pause_no_tick", o_phase, 32'h0);
    cyc(1, 3, 1, 16'h1234);
    check_val("load_over_tick", o_phase, 32'h1234);
    for (int i = 0; i < 3; i++) cyc(1, 3, 0, 0);
    check_val("cnt_restart", o_phase, 32'h1234);
    cyc(1, 3, 0, 0);
    check_val("tick_after_load", o_phase, 32'h1264);

    // reset while a strobe is pending
    n = 0;
    while (m_upd == 0 && n < 2 * DIV) begin
      cyc(1, 7, 0, 0);
      n++;
    end
    check_val("pending_found", m_upd, 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    check_val("midrst_phase", o_phase, 32'h0);
    check_val("midrst_valid", o_valid, 32'h0);
    check_val("midrst_addr", o_addr, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(1, 7, 0, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int en, ld, stp, lph;
      en  = ($urandom % 4 != 0) ? 1 : 0;
      ld  = ($urandom % 16 == 0) ? 1 : 0;
      stp = int'($urandom % 256) - 128;
      lph = int'($urandom % 65536);
      cyc(en, stp, ld, lph);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
